fp_to_int_cvt: RTL and testbench

Parametrised IEEE-754 binary floating-point to integer converter for the FPU's FCVT.W.S / FCVT.WU.S path. It supports signed or unsigned results per operation, all five RISC-V rounding modes, and RISC-V saturation and fflags (NV, NX) semantics. Operands and results move over valid/ready handshakes. Alignment is a multi-cycle iterative shifter, one bit per cycle.

---
 rtl/fp_to_int_cvt.sv | 124 ++++++++++++
 tb/tb_fp_to_int_cvt.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_cvt.sv
// fp_to_int_cvt: iterative IEEE-754 float to signed/unsigned integer converter with RISC-V rounding, saturation and flags
module fp_to_int_cvt #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic                     in_signed,
  input  logic [2:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_W-1:0]         out_z,
  output logic                     out_nv,
  output logic                     out_nx
);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam int B = 2 ** (EXP_W - 1) - 1;
  localparam int CW = $clog2(INT_W + MAN_W + 3);
  localparam logic [INT_W-1:0] UMAX = '1, SMAX = UMAX >> 1, SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, SPECIAL, ALIGN, ROUND, SAT, OUT} state_t;
  state_t st_q;
  logic [FW-1:0] a_q;
  logic sig_q, g_q, s_q, left_q, spec_q, nv_q, nx_q;
  logic [2:0] rm_q;
  logic [INT_W:0] mag_q;
  logic [CW-1:0] cnt_q;
  logic [INT_W-1:0] z_q, zs;
  logic sg, is_nan, is_inf, is_zero, big, left, inc, ovf;
  logic [EXP_W-1:0] ef;
  logic [MAN_W-1:0] mf;
  int e, sh;
  assign {sg, ef, mf} = a_q;
  assign in_ready = st_q == IDLE && !rst;
  assign out_valid = st_q == OUT;
  assign out_z = z_q;
  assign out_nv = nv_q;
  assign out_nx = nx_q;
  always_comb begin
    e = (ef == '0) ? 1 - B : int'({1'b0, ef}) - B;
    left = e >= MAN_W;
    sh = left ? e - MAN_W : (MAN_W - e > MAN_W + 2 ? MAN_W + 2 : MAN_W - e);
    is_nan = &ef && |mf;
    is_inf = &ef && ~|mf;
    is_zero = ~|ef && ~|mf;
    big = e >= INT_W;
    inc = rm_q == 3'd0 ? g_q & (s_q | mag_q[0]) :
          rm_q == 3'd2 ? sg & (g_q | s_q) :
          rm_q == 3'd3 ? ~sg & (g_q | s_q) :
          rm_q == 3'd4 ? g_q : 1'b0;
    ovf = sig_q ? (sg ? mag_q > {1'b0, SMIN} : mag_q > {1'b0, SMAX}) : (sg ? |mag_q : mag_q[INT_W]);
    zs = ovf ? (sig_q ? (sg ? SMIN : SMAX) : (sg ? '0 : UMAX)) :
               (sg ? -mag_q[INT_W-1:0] : mag_q[INT_W-1:0]);
  end
  // specials bypass the datapath but still pass through SAT so every result leaves via OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      a_q <= '0;
      sig_q <= 1'b0;
      rm_q <= '0;
      mag_q <= '0;
      g_q <= 1'b0;
      s_q <= 1'b0;
      left_q <= 1'b0;
      spec_q <= 1'b0;
      cnt_q <= '0;
      z_q <= '0;
      nv_q <= 1'b0;
      nx_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          a_q <= in_a;
          sig_q <= in_signed;
          rm_q <= in_rm;
          st_q <= SPECIAL;
        end
        SPECIAL: begin
          mag_q <= (INT_W+1)'({|ef, mf});
          g_q <= 1'b0;
          s_q <= 1'b0;
          left_q <= left;
          cnt_q <= CW'(sh);
          if (is_nan | is_inf | big | is_zero) begin
            z_q <= is_nan ? (sig_q ? SMAX : UMAX) :
                   is_zero ? '0 : (sg ? (sig_q ? SMIN : '0) : (sig_q ? SMAX : UMAX));
            nv_q <= ~is_zero;
            nx_q <= 1'b0;
            spec_q <= 1'b1;
            st_q <= SAT;
          end else begin
            spec_q <= 1'b0;
            st_q <= sh == 0 ? ROUND : ALIGN;
          end
        end
        ALIGN: begin
          mag_q <= left_q ? mag_q << 1 : mag_q >> 1;
          g_q <= left_q ? 1'b0 : mag_q[0];
          s_q <= left_q ? 1'b0 : s_q | g_q;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) st_q <= ROUND;
        end
        ROUND: begin
          mag_q <= mag_q + (INT_W+1)'(inc);
          st_q <= SAT;
        end
        SAT: begin
          if (!spec_q) begin
            z_q <= zs;
            nv_q <= ovf;
            nx_q <= ~ovf & (g_q | s_q);
          end
          st_q <= OUT;
        end
        OUT: if (out_ready) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int_cvt.sv
// tb_fp_to_int_cvt: directed vectors against an arithmetic reference model with per-cycle output checking
module tb_fp_to_int_cvt;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, in_signed = 0;
  logic out_valid, out_ready = 1, out_nv, out_nx;
  logic [31:0] in_a = '0, out_z;
  logic [2:0] in_rm = '0;
  int n_run = 0, n_fail = 0, cyc = 0, acc_cyc = 0, exp_lat = 0;
  logic [31:0] exp_z = '0;
  logic exp_nv = 0, exp_nx = 0, pv = 0;

  fp_to_int_cvt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_signed(in_signed), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_nv(out_nv), .out_nx(out_nx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // value = m * 2^(e-23); integer part and remainder decide rounding directly
  task automatic model(input logic [31:0] a, input logic sg, input logic [2:0] rm,
                       output logic [31:0] z, output logic nv, output logic nx, output int lat);
    int e, k;
    longint m, ip, rem, half, v;
    logic up, neg;
    neg = a[31];
    e = (a[30:23] == 8'h00) ? -126 : int'(a[30:23]) - 127;
    m = longint'({a[30:23] != 8'h00, a[22:0]});
    nx = 0;
    lat = 2;
    if (a[30:23] == 8'hFF && a[22:0] != 0) begin
      z = sg ? 32'h7FFFFFFF : 32'hFFFFFFFF;
      nv = 1;
    end else if (a[30:23] == 8'hFF || e >= 32) begin
      z = neg ? (sg ? 32'h80000000 : 32'h0) : (sg ? 32'h7FFFFFFF : 32'hFFFFFFFF);
      nv = 1;
    end else if (m == 0) begin
      z = 0;
      nv = 0;
    end else begin
      lat = 3 + (e >= 23 ? e - 23 : (23 - e > 25 ? 25 : 23 - e));
      if (e >= 23) begin
        ip = m << (e - 23);
        rem = 0;
        half = 1;
      end else begin
        k = 23 - e;
        if (k > 40) k = 40;
        ip = m >> k;
        rem = m & ((longint'(1) << k) - 1);
        half = longint'(1) << (k - 1);
      end
      up = rm == 3'd0 ? (rem > half || (rem == half && ip[0])) :
           rm == 3'd2 ? (neg && rem != 0) :
           rm == 3'd3 ? (!neg && rem != 0) :
           rm == 3'd4 ? (rem >= half) : 1'b0;
      ip = ip + longint'(up);
      v = neg ? -ip : ip;
      if (sg ? (v < -64'sd2147483648 || v > 64'sd2147483647) : (v < 0 || v > 64'sd4294967295)) begin
        z = sg ? (neg ? 32'h80000000 : 32'h7FFFFFFF) : (neg ? 32'h0 : 32'hFFFFFFFF);
        nv = 1;
      end else begin
        z = v[31:0];
        nv = 0;
        nx = rem != 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!pv) chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
      chk("z", out_z, exp_z);
      chk("nv", 32'(out_nv), 32'(exp_nv));
      chk("nx", 32'(out_nx), 32'(exp_nx));
      chk("in_ready_busy", 32'(in_ready), 32'(0));
    end
    pv = out_valid;
  end

  task automatic run(input logic [31:0] a, input logic sg, input logic [2:0] rm,
                     input logic [31:0] ez, input logic env, input logic enx, input int hold);
    logic [31:0] mz;
    logic mnv, mnx;
    int ml;
    bit ok;
    model(a, sg, rm, mz, mnv, mnx, ml);
    chk("model_z", mz, ez);
    chk("model_nv", 32'(mnv), 32'(env));
    chk("model_nx", 32'(mnx), 32'(enx));
    exp_z = mz;
    exp_nv = mnv;
    exp_nx = mnx;
    exp_lat = ml;
    @(negedge clk);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) if (in_ready) ok = 1; else @(negedge clk);
    if (!ok) chk("timeout_in_ready", 32'(0), 32'(1));
    in_a = a;
    in_signed = sg;
    in_rm = rm;
    in_valid = 1;
    out_ready = hold == 0;
    @(negedge clk);
    in_valid = 0;
    in_a = ~a;
    in_signed = ~sg;
    in_rm = 3'd1;
    if (hold > 0) begin
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) if (out_valid) ok = 1; else @(negedge clk);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'(1));
      end
      out_ready = 1;
    end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) if (out_valid && out_ready) ok = 1; else @(negedge clk);
    if (!ok) chk("timeout_out_valid", 32'(0), 32'(1));
    @(negedge clk);
    chk("consumed", 32'(out_valid), 32'(0));
  endtask

  initial begin
    logic [31:0] mz;
    logic mnv, mnx;
    int ml;
    #1 rst = 1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_z", out_z, 32'(0));
    chk("rst_nv", 32'(out_nv), 32'(0));
    chk("rst_nx", 32'(out_nx), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    repeat (2) @(negedge clk);
    rst = 0;
    model(32'h40490FDB, 1, 3'd0, mz, mnv, mnx, ml);
    chk("model_lat_pi", 32'(ml), 32'(25));
    run(32'h40490FDB, 1, 3'd0, 32'd3, 0, 1, 0);
    run(32'hC0300000, 1, 3'd0, 32'hFFFFFFFD, 0, 1, 0);
    run(32'hC0300000, 1, 3'd1, 32'hFFFFFFFE, 0, 1, 0);
    run(32'hC0300000, 1, 3'd2, 32'hFFFFFFFD, 0, 1, 0);
    run(32'hC0300000, 1, 3'd3, 32'hFFFFFFFE, 0, 1, 0);
    run(32'hC0300000, 1, 3'd4, 32'hFFFFFFFD, 0, 1, 0);
    run(32'h40200000, 1, 3'd0, 32'd2, 0, 1, 0);
    run(32'h40200000, 1, 3'd4, 32'd3, 0, 1, 0);
    run(32'h7FC00000, 1, 3'd0, 32'h7FFFFFFF, 1, 0, 0);
    run(32'hFF800000, 1, 3'd0, 32'h80000000, 1, 0, 0);
    run(32'h4F000000, 1, 3'd0, 32'h7FFFFFFF, 1, 0, 0);
    run(32'hCF000000, 1, 3'd0, 32'h80000000, 0, 0, 0);
    run(32'h7FC00000, 0, 3'd0, 32'hFFFFFFFF, 1, 0, 0);
    run(32'hFF800000, 0, 3'd0, 32'h0, 1, 0, 0);
    run(32'h4F000000, 0, 3'd0, 32'h80000000, 0, 0, 0);
    run(32'hBE800000, 0, 3'd1, 32'h0, 0, 1, 0);
    run(32'hBE800000, 0, 3'd2, 32'h0, 1, 0, 0);
    run(32'hBF800000, 0, 3'd0, 32'h0, 1, 0, 0);
    run(32'h00000000, 1, 3'd0, 32'h0, 0, 0, 0);
    run(32'h4EFFFFFF, 1, 3'd0, 32'h7FFFFF80, 0, 0, 0);
    run(32'h4F800000, 0, 3'd0, 32'hFFFFFFFF, 1, 0, 0);
    run(32'h80000001, 0, 3'd3, 32'h0, 0, 1, 0);
    run(32'h80000001, 1, 3'd2, 32'hFFFFFFFF, 0, 1, 0);
    run(32'hC0300000, 1, 3'd0, 32'hFFFFFFFD, 0, 1, 5);
    // abort a conversion part-way through its alignment shifts
    @(negedge clk);
    in_a = 32'h40490FDB;
    in_signed = 1;
    in_rm = 3'd0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'(0));
    chk("abort_z", out_z, 32'(0));
    chk("abort_nv", 32'(out_nv), 32'(0));
    chk("abort_nx", 32'(out_nx), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    chk("no_result_after_abort", 32'(out_valid), 32'(0));
    run(32'h3F800000, 1, 3'd0, 32'd1, 0, 0, 0);
    run(32'h40490FDB, 0, 3'd3, 32'd4, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
